// File: rtl/my_1bit_alu_v2.sv
// my_1bit_alu_v2: one bit slice of a chainable ALU.
// Each operand may be inverted before use. The slice does AND, OR, full-adder
// ADD and XOR. Result and carry are registered on one clock edge. A subtract is
// formed by setting binvert and driving carryIn=1 into the LSB slice.
module my_1bit_alu_v2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       in1,
   input  logic       in2,
   input  logic       carryIn,
   input  logic       ainvert,
   input  logic       binvert,
   input  logic [1:0] op,
   output logic       carryOut,
   output logic       result
);

   logic ea;
   logic eb;
   logic sum;
   logic cout;
   logic result_d;
   logic carry_out_d;
   logic result_q;
   logic carry_out_q;

   // Condition the operands, run the adder unconditionally so the chained carry is always valid, then pick the result.
   always_comb begin
      ea          = in1 ^ ainvert;
      eb          = in2 ^ binvert;
      sum         = ea ^ eb ^ carryIn;
      cout        = (ea & eb) | (ea & carryIn) | (eb & carryIn);
      result_d    = op[1] ? (op[0] ? (ea ^ eb) : sum)
                          : (op[0] ? (ea | eb) : (ea & eb));
      carry_out_d = cout;
   end

   // Output register; reset clears both bits right away, without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q    <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
      end
   end

   assign result   = result_q;
   assign carryOut = carry_out_q;

endmodule

// File: tb/tb_my_1bit_alu_v2.sv
// tb_my_1bit_alu_v2: scoreboard bench for the 1-bit ALU slice.
// Stimulus pushes the expected {result, carryOut} pair from an arithmetic reference model.
// A separate monitor pops one entry after each active edge and compares.
module tb_my_1bit_alu_v2;

   logic       clk;
   logic       rst;
   logic       in1;
   logic       in2;
   logic       carryIn;
   logic       ainvert;
   logic       binvert;
   logic [1:0] op;
   logic       carryOut;
   logic       result;

   int         checks;
   int         failures;
   logic [1:0] expQ[$];
   string      nameQ[$];

   my_1bit_alu_v2 dut (
      .clk      (clk),
      .rst      (rst),
      .in1      (in1),
      .in2      (in2),
      .carryIn  (carryIn),
      .ainvert  (ainvert),
      .binvert  (binvert),
      .op       (op),
      .carryOut (carryOut),
      .result   (result)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model built from the arithmetic meaning of each operation.
   // It returns {result, carry}.
   function automatic logic [1:0] refModel(input int a, input int b, input int ci,
                                           input int ai, input int bi, input int o);
      int effA;
      int effB;
      int total;
      int res;
      effA  = ai ? 1 - a : a;
      effB  = bi ? 1 - b : b;
      total = effA + effB + ci;
      case (o)
         0:       res = effA * effB;
         1:       res = (effA + effB > 0) ? 1 : 0;
         2:       res = total % 2;
         default: res = (effA + effB == 1) ? 1 : 0;
      endcase
      return {res[0], (total >= 2)};
   endfunction

   // Compare one observed pair against the required pair.
   task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got result/carryOut=%b required=%b at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one operation on the falling edge and queue its expected response for the next rising edge.
   task automatic applyStimulus(input string name, input int a, input int b, input int ci,
                                input int ai, input int bi, input int o);
      @(negedge clk);
      in1     = a[0];
      in2     = b[0];
      carryIn = ci[0];
      ainvert = ai[0];
      binvert = bi[0];
      op      = o[1:0];
      expQ.push_back(refModel(a, b, ci, ai, bi, o));
      nameQ.push_back(name);
   endtask

   // Monitor: every output register update is compared against the oldest queued expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst && expQ.size() > 0) begin
            checkOutput(nameQ.pop_front(), {result, carryOut}, expQ.pop_front());
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      in1      = 1'b0;
      in2      = 1'b0;
      carryIn  = 1'b0;
      ainvert  = 1'b0;
      binvert  = 1'b0;
      op       = 2'd0;

      // Reset holds the outputs low, then releases. The first edge after release captures the inputs.
      repeat (2) @(posedge clk);
      #1 checkOutput("reset_idle", {result, carryOut}, 2'b00);
      @(negedge clk);
      in1 = 1'b1;
      in2 = 1'b1;
      op  = 2'd1;
      @(posedge clk);
      #1 checkOutput("reset_hold_over_edge", {result, carryOut}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      #1 checkOutput("reset_release_no_edge", {result, carryOut}, 2'b00);
      @(posedge clk);
      #1 checkOutput("reset_release_first_edge", {result, carryOut}, 2'b11);

      // AND and OR sweeps across the three invert settings and all operand pairs.
      for (int o = 0; o < 2; o++) begin
         for (int inv = 0; inv < 3; inv++) begin
            for (int p = 0; p < 4; p++) begin
               applyStimulus($sformatf("logic_op%0d_inv%0d_ab%0d", o, inv, p),
                             p / 2, p % 2, $urandom_range(0, 1),
                             (inv == 2) ? 1 : 0, (inv >= 1) ? 1 : 0, o);
            end
         end
      end

      // ADD with no inversion, all eight input combinations.
      for (int v = 0; v < 8; v++) begin
         applyStimulus($sformatf("add_%0d", v), (v >> 2) & 1, (v >> 1) & 1, v & 1, 0, 0, 2);
      end

      // Subtract slice: binvert with carryIn=1.
      for (int p = 0; p < 4; p++) begin
         applyStimulus($sformatf("sub_ab%0d", p), p / 2, p % 2, 1, 0, 1, 2);
      end

      // XOR, including its carry, issued back to back.
      applyStimulus("xor_10", 1, 0, 0, 0, 0, 3);
      applyStimulus("xor_11", 1, 1, 0, 0, 0, 3);
      applyStimulus("xor_11_cin", 1, 1, 1, 0, 0, 3);
      applyStimulus("xor_01_cin", 0, 1, 1, 0, 0, 3);

      // Random traffic with the inputs changing every cycle.
      for (int i = 0; i < 200; i++) begin
         applyStimulus($sformatf("rand_%0d", i), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 3));
      end

      // Asserting reset mid-cycle clears a registered 1 at once, and holds it over an edge.
      applyStimulus("pre_reset_or", 1, 1, 1, 0, 0, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 checkOutput("reset_async_mid_cycle", {result, carryOut}, 2'b00);
      in1 = 1'b1;
      in2 = 1'b1;
      op  = 2'd2;
      @(posedge clk);
      #1 checkOutput("reset_async_hold", {result, carryOut}, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         applyStimulus($sformatf("post_reset_rand_%0d", i), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 3));
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int w = 0; w < 10 && expQ.size() > 0; w++) begin
         @(posedge clk);
         #2;
      end
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain_timeout: %0d expectations left, required 0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
